// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the control sequencer: opcodes, state codes and
// the control-field code values driven onto the datapath.
package control_sequencer_pkg;

   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_COPY  = 4'h3;
   localparam logic [3:0] OP_JUMP  = 4'h4;
   localparam logic [3:0] OP_ADD   = 4'h5;
   localparam logic [3:0] OP_SUB   = 4'h6;
   localparam logic [3:0] OP_MUL   = 4'h7;
   localparam logic [3:0] OP_DIV   = 4'h8;
   localparam logic [3:0] OP_CLR   = 4'h9;
   localparam logic [3:0] OP_INC   = 4'hA;
   localparam logic [3:0] OP_DEC   = 4'hB;
   localparam logic [3:0] OP_LOADK = 4'hC;
   localparam logic [3:0] OP_END   = 4'hF;

   // First execute state of each opcode carries the opcode in its low
   // nibble; the second execute state adds 8'h10. LED shows bits [5:0].
   typedef enum logic [7:0] {
      S_IDLE   = 8'h00,
      S_LOAD1  = 8'h01,
      S_STORE1 = 8'h02,
      S_COPY1  = 8'h03,
      S_JUMP   = 8'h04,
      S_ADD1   = 8'h05,
      S_SUB1   = 8'h06,
      S_MUL1   = 8'h07,
      S_DIV1   = 8'h08,
      S_CLR    = 8'h09,
      S_INC    = 8'h0A,
      S_DEC    = 8'h0B,
      S_LOADK  = 8'h0C,
      S_END    = 8'h0F,
      S_LOAD2  = 8'h11,
      S_STORE2 = 8'h12,
      S_COPY2  = 8'h13,
      S_ADD2   = 8'h15,
      S_SUB2   = 8'h16,
      S_MUL2   = 8'h17,
      S_DIV2   = 8'h18,
      S_FETCH1 = 8'h20,
      S_FETCH2 = 8'h21,
      S_TRAP   = 8'h30,
      S_DONE   = 8'h31
   } state_e;

   localparam logic [3:0] ALU_NONE  = 4'b0000;
   localparam logic [3:0] ALU_ADD   = 4'b0001;
   localparam logic [3:0] ALU_SUB   = 4'b0010;
   localparam logic [3:0] ALU_MUL   = 4'b0011;
   localparam logic [3:0] ALU_DIV   = 4'b0100;
   localparam logic [3:0] ALU_COPY  = 4'b0101;
   localparam logic [3:0] ALU_LOADK = 4'b0110;
   localparam logic [3:0] ALU_INC   = 4'b0111;
   localparam logic [3:0] ALU_DEC   = 4'b1000;
   localparam logic [3:0] ALU_CLR   = 4'b1001;

   localparam logic [1:0] IDC_NONE = 2'b00;
   localparam logic [1:0] IDC_INC  = 2'b01;
   localparam logic [1:0] IDC_DEC  = 2'b10;
   localparam logic [1:0] IDC_CLR  = 2'b11;

   localparam logic [1:0] MDR_NONE = 2'b00;
   localparam logic [1:0] MDR_LOAD = 2'b01;
   localparam logic [1:0] MDR_COPY = 2'b10;

   localparam logic [1:0] MAR_NONE  = 2'b00;
   localparam logic [1:0] MAR_SRC1  = 2'b01;
   localparam logic [1:0] MAR_LOAD2 = 2'b10;
   localparam logic [1:0] MAR_STOR2 = 2'b11;

   localparam logic [1:0] PC_NONE = 2'b00;
   localparam logic [1:0] PC_INC  = 2'b01;
   localparam logic [1:0] PC_JUMP = 2'b10;

   // Source select used by MUL/DIV operand staging.
   localparam logic [3:0] SEL_SRC_MULDIV = 4'b1011;

   function automatic state_e first_exec_state(input logic [3:0] op);
      case (op)
         OP_LOAD:  return S_LOAD1;
         OP_STORE: return S_STORE1;
         OP_COPY:  return S_COPY1;
         OP_JUMP:  return S_JUMP;
         OP_ADD:   return S_ADD1;
         OP_SUB:   return S_SUB1;
         OP_MUL:   return S_MUL1;
         OP_DIV:   return S_DIV1;
         OP_CLR:   return S_CLR;
         OP_INC:   return S_INC;
         OP_DEC:   return S_DEC;
         OP_LOADK: return S_LOADK;
         OP_END:   return S_END;
         default:  return S_TRAP;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_wait_timer.sv
// Memory-wait timer: down-counter reloaded on entry to a wait state,
// expired when it reaches terminal count zero.
module wait_timer #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         tick,
   input  logic [W-1:0] limit,
   output logic         expired
);

   logic [W-1:0] count;

   // Reload on clear, count down while waiting, stop at zero.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= limit;
      end else if (tick && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer: fetches a 16-bit instruction, steps through one
// or two execute states per opcode and drives datapath controls.
//
//  state          | meaning
//  ---------------+----------------------------------------------
//  IDLE           | stopped, waits for enable_processor
//  FETCH1         | load_instruction; drop to IDLE if disabled
//  FETCH2         | PC increment, IR latched, opcode dispatch
//  <op>1 / <op>2  | execute steps (LOAD2/STORE2 wait mem_ready,
//                 | MUL2/DIV2 optionally wait alu_done)
//  END            | one-cycle start_Tx pulse
//  DONE           | waits for tx_done, then IDLE
//  TRAP           | illegal opcode or memory timeout
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int SRC_W       = 4,
   parameter int DST_W       = 3,
   parameter int MULDIV_WAIT = 1,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable_processor,
   input  logic [15:0]      instruction,
   input  logic             mem_ready,
   input  logic             alu_done,
   input  logic             tx_done,
   output logic             load_instruction,
   output logic [3:0]       ALU_control,
   output logic [SRC_W-1:0] select_source,
   output logic [DST_W-1:0] select_destination,
   output logic [1:0]       IDC_control,
   output logic [1:0]       MDR_control,
   output logic [1:0]       MAR_control,
   output logic [1:0]       PC_control,
   output logic             write_DRAM,
   output logic             start_Tx,
   output logic             busy,
   output logic             illegal_op,
   output logic [5:0]       LED
);

   typedef struct packed {
      logic             load_instruction;
      logic [3:0]       alu;
      logic [SRC_W-1:0] src;
      logic [DST_W-1:0] dst;
      logic [1:0]       idc;
      logic [1:0]       mdr;
      logic [1:0]       mar;
      logic [1:0]       pc;
      logic             write_dram;
      logic             start_tx;
      logic             busy;
      logic             illegal_op;
   } ctrl_t;

   state_e           state, nxt_state;
   logic [SRC_W-1:0] ir_src, nxt_src;
   logic [DST_W-1:0] ir_dst, nxt_dst;
   ctrl_t            ctrl;
   logic             wait_clear, wait_tick, wait_expired;
   logic             unused_bits;

   // Moore decode of a state and the IR fields it operates on.
   function automatic ctrl_t decode(input state_e s,
                                    input logic [SRC_W-1:0] src,
                                    input logic [DST_W-1:0] dst);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH1: c.load_instruction = 1'b1;
         S_FETCH2: c.pc = PC_INC;
         S_ADD1, S_SUB1, S_COPY1: c.src = src;
         S_ADD2:   c.alu = ALU_ADD;
         S_SUB2:   c.alu = ALU_SUB;
         S_MUL1, S_DIV1: c.src = SRC_W'(SEL_SRC_MULDIV);
         S_MUL2:   c.alu = ALU_MUL;
         S_DIV2:   c.alu = ALU_DIV;
         S_COPY2: begin
            // dst=1 routes through the ALU; dst=5 also loads the MDR.
            if (dst == DST_W'(1)) begin
               c.alu = ALU_COPY;
            end else begin
               c.dst = dst;
               if (dst == DST_W'(5)) c.mdr = MDR_COPY;
            end
         end
         S_LOADK:  c.alu = ALU_LOADK;
         S_JUMP:   c.pc = PC_JUMP;
         S_INC: if (src == SRC_W'(1)) c.alu = ALU_INC; else c.idc = IDC_INC;
         S_DEC: if (src == SRC_W'(1)) c.alu = ALU_DEC; else c.idc = IDC_DEC;
         S_CLR: if (src == SRC_W'(1)) c.alu = ALU_CLR; else c.idc = IDC_CLR;
         S_LOAD1: begin
            if (src == SRC_W'(1))      c.mar = MAR_SRC1;
            else if (src == SRC_W'(2)) c.mar = MAR_LOAD2;
         end
         S_STORE1: begin
            if (src == SRC_W'(1))      c.mar = MAR_SRC1;
            else if (src == SRC_W'(2)) c.mar = MAR_STOR2;
         end
         S_LOAD2:  c.mdr = MDR_LOAD;
         S_STORE2: c.write_dram = 1'b1;
         S_END:    c.start_tx = 1'b1;
         S_TRAP:   c.illegal_op = 1'b1;
         default:  ;
      endcase
      c.busy = !(s inside {S_IDLE, S_TRAP, S_DONE});
      return c;
   endfunction

   // Next-state and IR-capture logic.
   always_comb begin
      nxt_state = state;
      nxt_src   = ir_src;
      nxt_dst   = ir_dst;
      case (state)
         S_IDLE:   if (enable_processor) nxt_state = S_FETCH1;
         S_FETCH1: nxt_state = enable_processor ? S_FETCH2 : S_IDLE;
         S_FETCH2: begin
            nxt_src   = instruction[8 +: SRC_W];
            nxt_dst   = instruction[DST_W-1:0];
            nxt_state = first_exec_state(instruction[15:12]);
         end
         S_LOAD1:  nxt_state = S_LOAD2;
         S_STORE1: nxt_state = S_STORE2;
         S_COPY1:  nxt_state = S_COPY2;
         S_ADD1:   nxt_state = S_ADD2;
         S_SUB1:   nxt_state = S_SUB2;
         S_MUL1:   nxt_state = S_MUL2;
         S_DIV1:   nxt_state = S_DIV2;
         S_COPY2, S_ADD2, S_SUB2, S_JUMP, S_CLR, S_INC, S_DEC, S_LOADK:
            nxt_state = S_FETCH1;
         S_MUL2, S_DIV2:
            if ((MULDIV_WAIT == 0) || alu_done) nxt_state = S_FETCH1;
         S_LOAD2, S_STORE2: begin
            if (mem_ready)         nxt_state = S_FETCH1;
            else if (wait_expired) nxt_state = S_TRAP;
         end
         S_END:    nxt_state = S_DONE;
         S_DONE:   if (tx_done) nxt_state = S_IDLE;
         S_TRAP:   if (!enable_processor) nxt_state = S_IDLE;
         default:  nxt_state = S_IDLE;
      endcase
   end

   // State, IR and outputs registered together; outputs are decoded from
   // the next state so they always match the current state and IR.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         ir_src <= '0;
         ir_dst <= '0;
         ctrl   <= '0;
      end else begin
         state  <= nxt_state;
         ir_src <= nxt_src;
         ir_dst <= nxt_dst;
         ctrl   <= decode(nxt_state, nxt_src, nxt_dst);
      end
   end

   // Timer reloads in LOAD1/STORE1 so it is fresh on the first wait cycle;
   // the limit counts the expiring cycle itself.
   assign wait_clear = (state == S_LOAD1) || (state == S_STORE1);
   assign wait_tick  = (state == S_LOAD2) || (state == S_STORE2);

   wait_timer #(.W(8)) u_wait_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (wait_clear),
      .tick    (wait_tick),
      .limit   (8'(MEM_TIMEOUT - 1)),
      .expired (wait_expired)
   );

   assign load_instruction   = ctrl.load_instruction;
   assign ALU_control        = ctrl.alu;
   assign select_source      = ctrl.src;
   assign select_destination = ctrl.dst;
   assign IDC_control        = ctrl.idc;
   assign MDR_control        = ctrl.mdr;
   assign MAR_control        = ctrl.mar;
   assign PC_control         = ctrl.pc;
   assign write_DRAM         = ctrl.write_dram;
   assign start_Tx           = ctrl.start_tx;
   assign busy               = ctrl.busy;
   assign illegal_op         = ctrl.illegal_op;
   assign LED                = state[5:0];

   // Instruction bits outside the opcode/src/dst fields are don't-care.
   assign unused_bits = ^{instruction, state};

endmodule
